// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one single-port, fixed-latency memory between the
//                fetch stage (IF) and the load/store unit (LS). LS normally
//                wins; an IF anti-starvation counter forces IF to win after
//                STARVE_MAX consecutive LS wins over a pending IF request.
//  Ports       : clk_i/rst_i            clock, synchronous active-high reset
//                if_req_i/if_addr_i     fetch request and address
//                if_gnt_o/if_rvalid_o   fetch grant / read-data-valid pulse
//                if_rdata_o             fetched instruction
//                ls_req_i/ls_we_i       LSU request, 1 = store
//                ls_addr_i/ls_wdata_i   LSU address and store data
//                ls_bmask_i             LSU byte mask
//                ls_gnt_o/ls_rvalid_o   LSU grant / load-data or store-done
//                ls_rdata_o             load data (0 for stores)
//                mem_*                  memory macro strobe, controls, data
//                busy_o                 access in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    input  logic [3:0]  ls_bmask_i,
    output logic        ls_gnt_o,
    output logic        ls_rvalid_o,
    output logic [31:0] ls_rdata_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_bmask_o,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o
);

    localparam int LW = $clog2(LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          owner_q, owner_d;
    logic          store_q, store_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic          ls_rvalid_q, ls_rvalid_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   ls_rdata_q, ls_rdata_d;

    logic          idle;
    logic          starved;
    logic          if_win;
    logic          ls_win;
    logic          lat_done;
    logic [31:0]   cap_data;

    // Grants are suppressed during reset so a requester never sees a grant
    // for an access that the reset is about to discard.
    assign idle     = (state_q == S_IDLE) && !rst_i;
    assign starved  = (starve_cnt_q == SW'(STARVE_MAX));
    assign if_win   = idle && if_req_i && (!ls_req_i || starved);
    assign ls_win   = idle && ls_req_i && !if_win;
    assign lat_done = (state_q == S_BUSY) && (lat_cnt_q == LW'(LAT));
    // Stores share the load timing but return zero data.
    assign cap_data = store_q ? 32'h0 : mem_rdata_i;

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        owner_d      = owner_q;
        store_d      = store_q;
        if_rvalid_d  = 1'b0;
        ls_rvalid_d  = 1'b0;
        if_rdata_d   = if_rdata_q;
        ls_rdata_d   = ls_rdata_q;

        if (if_win || ls_win) begin
            state_d   = S_BUSY;
            lat_cnt_d = LW'(1);
            owner_d   = ls_win ? OWN_LS : OWN_IF;
            store_d   = ls_win && ls_we_i;
            if (if_win) begin
                starve_cnt_d = '0;
            end else if (if_req_i && !starved) begin
                starve_cnt_d = starve_cnt_q + SW'(1);
            end
        end else if (state_q == S_BUSY) begin
            if (lat_done) begin
                state_d   = S_IDLE;
                lat_cnt_d = '0;
                if (owner_q == OWN_LS) begin
                    ls_rdata_d  = cap_data;
                    ls_rvalid_d = 1'b1;
                end else begin
                    if_rdata_d  = cap_data;
                    if_rvalid_d = 1'b1;
                end
            end else begin
                lat_cnt_d = lat_cnt_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            owner_q      <= OWN_IF;
            store_q      <= 1'b0;
            if_rvalid_q  <= 1'b0;
            ls_rvalid_q  <= 1'b0;
            if_rdata_q   <= 32'h0;
            ls_rdata_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
            store_q      <= store_d;
            if_rvalid_q  <= if_rvalid_d;
            ls_rvalid_q  <= ls_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            ls_rdata_q   <= ls_rdata_d;
        end
    end

    // IF accesses are always full-word reads.
    assign if_gnt_o    = if_win;
    assign ls_gnt_o    = ls_win;
    assign mem_en_o    = if_win || ls_win;
    assign mem_we_o    = ls_win && ls_we_i;
    assign mem_addr_o  = ls_win ? ls_addr_i  : (if_win ? if_addr_i : 32'h0);
    assign mem_wdata_o = ls_win ? ls_wdata_i : 32'h0;
    assign mem_bmask_o = ls_win ? ls_bmask_i : (if_win ? 4'hF : 4'h0);

    assign if_rvalid_o = if_rvalid_q;
    assign ls_rvalid_o = ls_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign ls_rdata_o  = ls_rdata_q;
    assign busy_o      = (state_q == S_BUSY);

endmodule
`default_nettype wire
